// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the Galois LFSR generator.
package lfsr_pkg;

  localparam int MAX_W = 32;

  // Maximal-length Galois right-shift masks, indexed by width (4..32).
  // Bit i set means feedback is XORed into bit i.
  localparam logic [MAX_W-1:0] MAX_TAPS [4:32] = '{
    32'h0000000C, 32'h00000014, 32'h00000030, 32'h00000060,   // 4..7
    32'h000000B8, 32'h00000110, 32'h00000240, 32'h00000500,   // 8..11
    32'h00000E08, 32'h00001C80, 32'h00003802, 32'h00006000,   // 12..15
    32'h0000D008, 32'h00012000, 32'h00020400, 32'h00072000,   // 16..19
    32'h00090000, 32'h00140000, 32'h00300000, 32'h00420000,   // 20..23
    32'h00E10000, 32'h01200000, 32'h02000023, 32'h04000013,   // 24..27
    32'h09000000, 32'h14000000, 32'h20000029, 32'h48000000,   // 28..31
    32'h80200003                                              // 32
  };

  // Default tap mask for a given width; widths 2 and 3 have trivial
  // maximal masks, anything out of range yields zero.
  function automatic logic [MAX_W-1:0] default_taps(input int width);
    logic [MAX_W-1:0] t;
    t = '0;
    if (width == 2)                        t = 32'h3;
    else if (width == 3)                   t = 32'h6;
    else if (width >= 4 && width <= MAX_W) t = MAX_TAPS[width];
    return t;
  endfunction

  // One Galois right shift. Callers zero-extend narrower state/taps, so
  // the unused upper bits stay zero.
  function automatic logic [MAX_W-1:0] galois_shift(input logic [MAX_W-1:0] s,
                                                    input logic [MAX_W-1:0] t);
    return (s >> 1) ^ (s[0] ? t : '0);
  endfunction

endpackage

// File: rtl/lfsr_step_comb.sv
// Combinational STEPS-deep chain of Galois shifts.
module lfsr_step_comb
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEPS = 1
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic [WIDTH-1:0] taps_i,
  output logic [WIDTH-1:0] state_o
);

  logic [STEPS:0][MAX_W-1:0] chain;

  assign chain[0] = MAX_W'(state_i);

  // Unrolled shift chain: link i+1 is link i shifted once.
  for (genvar i = 0; i < STEPS; i++) begin : g_shift
    assign chain[i+1] = galois_shift(chain[i], MAX_W'(taps_i));
  end

  assign state_o = chain[STEPS][WIDTH-1:0];

  // Upper bits are always zero for narrow instances.
  if (WIDTH < MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^chain[STEPS][MAX_W-1:WIDTH];
  end

endmodule

// File: rtl/lfsr_gen.sv
// Seedable Galois LFSR with runtime taps, lock-up recovery and a period monitor.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] TAPS_DEFAULT = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1),
  parameter int               CNT_W        = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  input  logic             seed_we,
  input  logic [WIDTH-1:0] seed,
  input  logic             taps_we,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] state,
  output logic             out_bit,
  output logic             wrap,
  output logic [CNT_W-1:0] period_last,
  output logic             lockup
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] seed_val;

  // Next state always uses the taps currently held, so a same-cycle
  // taps write only affects later steps.
  lfsr_step_comb #(.WIDTH(WIDTH), .STEPS(STEPS)) u_step (
    .state_i (state_q),
    .taps_i  (taps_q),
    .state_o (next_state)
  );

  assign seed_val = (seed == '0) ? SEED_DEFAULT : seed;

  // Priority: seed load, then step (with zero-state recovery); else hold.
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    taps_d   = taps_we ? taps : taps_q;
    if (seed_we) begin
      state_d = seed_val;
      ref_d   = seed_val;
      cnt_d   = '0;
    end else if (step_en) begin
      if (state_q == '0) begin
        state_d  = SEED_DEFAULT;
        ref_d    = SEED_DEFAULT;
        cnt_d    = '0;
        lockup_d = 1'b1;
      end else begin
        state_d = next_state;
        if (next_state == ref_q) begin
          wrap_d   = 1'b1;
          period_d = cnt_q + CNT_W'(1);
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Register bank with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SEED_DEFAULT;
      taps_q   <= TAPS_DEFAULT;
      ref_q    <= SEED_DEFAULT;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      taps_q   <= taps_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign state       = state_q;
  assign out_bit     = state_q[0];
  assign wrap        = wrap_q;
  assign period_last = period_q;
  assign lockup      = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: one STEPS=1 and one STEPS=2 instance driven in parallel.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_en = 1'b0;
  logic       seed_we = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       taps_we = 1'b0;
  logic [7:0] taps = 8'h00;

  logic [7:0] state_a, state_b, per_a, per_b;
  logic       obit_a, obit_b, wrap_a, wrap_b, lock_a, lock_b;

  int total = 0;
  int bad   = 0;

  // Reference model, one slot per instance (slot k shifts k+1 times).
  int m_state [2];
  int m_ref   [2];
  int m_cnt   [2];
  int m_per   [2];
  int m_wrap  [2];
  int m_lock  [2];
  int m_taps;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(8), .STEPS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .seed_we(seed_we), .seed(seed),
    .taps_we(taps_we), .taps(taps), .state(state_a), .out_bit(obit_a),
    .wrap(wrap_a), .period_last(per_a), .lockup(lock_a)
  );

  lfsr_gen #(.WIDTH(8), .STEPS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .seed_we(seed_we), .seed(seed),
    .taps_we(taps_we), .taps(taps), .state(state_b), .out_bit(obit_b),
    .wrap(wrap_b), .period_last(per_b), .lockup(lock_b)
  );

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Spec rules in plain integer arithmetic for one instance.
  task automatic model(input int k, input bit r, input bit st, input bit sw, input int sd);
    int nx;
    if (!r) begin
      m_state[k] = 1; m_ref[k] = 1; m_cnt[k] = 0; m_per[k] = 0;
      m_wrap[k] = 0;  m_lock[k] = 0;
    end else begin
      m_wrap[k] = 0; m_lock[k] = 0;
      if (sw) begin
        m_state[k] = (sd == 0) ? 1 : sd;
        m_ref[k]   = m_state[k];
        m_cnt[k]   = 0;
      end else if (st) begin
        if (m_state[k] == 0) begin
          m_state[k] = 1; m_ref[k] = 1; m_cnt[k] = 0; m_lock[k] = 1;
        end else begin
          nx = m_state[k];
          for (int i = 0; i <= k; i++)
            nx = (nx / 2) ^ ((nx % 2 == 1) ? m_taps : 0);
          m_state[k] = nx;
          if (nx == m_ref[k]) begin
            m_wrap[k] = 1;
            m_per[k]  = (m_cnt[k] + 1) % 256;
            m_cnt[k]  = 0;
          end else begin
            m_cnt[k] = (m_cnt[k] + 1) % 256;
          end
        end
      end
    end
  endtask

  // Drive one cycle, advance the model, then compare both instances.
  task automatic tick(input bit r, input bit st, input bit sw, input logic [7:0] sd,
                      input bit tw, input logic [7:0] tp);
    rst_n = r; step_en = st; seed_we = sw; seed = sd; taps_we = tw; taps = tp;
    model(0, r, st, sw, int'(sd));
    model(1, r, st, sw, int'(sd));
    if (!r)      m_taps = 8'hB8;
    else if (tw) m_taps = int'(tp);
    @(posedge clk);
    #1;
    check("a.state",  int'(state_a), m_state[0]);
    check("a.outbit", int'(obit_a),  m_state[0] % 2);
    check("a.wrap",   int'(wrap_a),  m_wrap[0]);
    check("a.lockup", int'(lock_a),  m_lock[0]);
    check("a.period", int'(per_a),   m_per[0]);
    check("b.state",  int'(state_b), m_state[1]);
    check("b.outbit", int'(obit_b),  m_state[1] % 2);
    check("b.wrap",   int'(wrap_b),  m_wrap[1]);
    check("b.lockup", int'(lock_b),  m_lock[1]);
    check("b.period", int'(per_b),   m_per[1]);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) tick(1, 1, 0, 8'h00, 0, 8'h00);
  endtask

  typedef struct {
    bit         rst_n, step, swe;
    logic [7:0] seed;
    bit         twe;
    logic [7:0] taps;
    logic [7:0] e_state;
    bit         e_wrap, e_lock;
    logic [7:0] e_per;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int wraps_a, wraps_b;
    int r, sel;
    logic [7:0] sd, tp;

    //          rst step swe seed  twe taps   state  wrap lock per
    tbl[0]  = '{0,  0,   0,  8'h00, 0, 8'h00, 8'h01, 0, 0, 8'h00};
    tbl[1]  = '{1,  0,   1,  8'h01, 0, 8'h00, 8'h01, 0, 0, 8'h00};
    tbl[2]  = '{1,  1,   0,  8'h00, 0, 8'h00, 8'hB8, 0, 0, 8'h00};
    tbl[3]  = '{1,  1,   0,  8'h00, 0, 8'h00, 8'h5C, 0, 0, 8'h00};
    tbl[4]  = '{1,  1,   0,  8'h00, 0, 8'h00, 8'h2E, 0, 0, 8'h00};
    tbl[5]  = '{1,  1,   0,  8'h00, 0, 8'h00, 8'h17, 0, 0, 8'h00};
    tbl[6]  = '{1,  1,   0,  8'h00, 0, 8'h00, 8'hB3, 0, 0, 8'h00};
    tbl[7]  = '{1,  1,   1,  8'h00, 0, 8'h00, 8'h01, 0, 0, 8'h00};
    tbl[8]  = '{1,  0,   0,  8'h00, 1, 8'h00, 8'h01, 0, 0, 8'h00};
    tbl[9]  = '{1,  1,   0,  8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00};
    tbl[10] = '{1,  1,   0,  8'h00, 0, 8'h00, 8'h01, 0, 1, 8'h00};
    tbl[11] = '{1,  1,   0,  8'h00, 1, 8'hB8, 8'h00, 0, 0, 8'h00};
    tbl[12] = '{1,  0,   0,  8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00};
    tbl[13] = '{1,  1,   0,  8'h00, 0, 8'h00, 8'h01, 0, 1, 8'h00};
    tbl[14] = '{1,  1,   0,  8'h00, 0, 8'h00, 8'hB8, 0, 0, 8'h00};

    m_taps = 8'hB8;
    repeat (2) @(posedge clk);
    #1;

    // Directed table on the STEPS=1 instance.
    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].rst_n, tbl[i].step, tbl[i].swe, tbl[i].seed, tbl[i].twe, tbl[i].taps);
      check($sformatf("tbl%0d.state", i), int'(state_a), int'(tbl[i].e_state));
      check($sformatf("tbl%0d.wrap", i),  int'(wrap_a),  int'(tbl[i].e_wrap));
      check($sformatf("tbl%0d.lock", i),  int'(lock_a),  int'(tbl[i].e_lock));
      check($sformatf("tbl%0d.per", i),   int'(per_a),   int'(tbl[i].e_per));
    end

    // STEPS=2: one enabled cycle from seed 0x01 lands on 0x5C.
    tick(0, 0, 0, 8'h00, 0, 8'h00);
    tick(1, 0, 1, 8'h01, 0, 8'h00);
    tick(1, 1, 0, 8'h00, 0, 8'h00);
    check("b.one_cycle", int'(state_b), 8'h5C);
    check("a.one_cycle", int'(state_a), 8'hB8);

    // Full-period run: wraps at enabled cycles 255 and 510 only.
    tick(0, 1, 0, 8'h00, 0, 8'h00);
    wraps_a = 0; wraps_b = 0;
    for (int i = 1; i <= 510; i++) begin
      tick(1, 1, 0, 8'h00, 0, 8'h00);
      wraps_a += int'(wrap_a);
      wraps_b += int'(wrap_b);
      if (i == 255 || i == 510) begin
        check($sformatf("a.wrap@%0d", i), int'(wrap_a), 1);
        check($sformatf("a.st@%0d", i),   int'(state_a), 8'h01);
        check($sformatf("a.per@%0d", i),  int'(per_a), 255);
        check($sformatf("b.wrap@%0d", i), int'(wrap_b), 1);
        check($sformatf("b.per@%0d", i),  int'(per_b), 255);
      end
    end
    check("a.wrap_count", wraps_a, 2);
    check("b.wrap_count", wraps_b, 2);

    // Mid-sequence reset with step held: count discarded, restart from seed.
    step_n(100);
    tick(0, 1, 0, 8'h00, 0, 8'h00);
    check("rst.state",  int'(state_a), 8'h01);
    check("rst.period", int'(per_a), 0);
    wraps_a = 0;
    for (int i = 1; i <= 255; i++) begin
      tick(1, 1, 0, 8'h00, 0, 8'h00);
      wraps_a += int'(wrap_a);
    end
    check("rst.wrap_last", int'(wrap_a), 1);
    check("rst.wrap_count", wraps_a, 1);
    check("rst.per", int'(per_a), 255);

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      r   = $urandom_range(0, 99);
      sel = $urandom_range(0, 3);
      sd  = (sel == 0) ? 8'h00 : 8'($urandom);
      sel = $urandom_range(0, 2);
      tp  = (sel == 0) ? 8'hB8 : (sel == 1) ? 8'($urandom) : (8'($urandom) & 8'h7F);
      tick(r != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, sd,
           $urandom_range(0, 31) == 0, tp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised successor to the 8-bit seedable LFSR that drives the tile's output pins.
- Galois LFSR with generic WIDTH, runtime-writable tap mask, and STEPS shifts per enabled cycle.
- Zero-state lock-up recovery, plus a period monitor that flags return to the seed and reports the measured period.
- Sits directly behind the top-level pin wrapper; state drives uo_out, and control comes from ui_in/uio_in.

Parameters:
- WIDTH, 8, LFSR state width in bits (2..32).
- STEPS, 1, LFSR shifts applied per enabled cycle (1..WIDTH).
- TAPS_DEFAULT, 8'hB8, reset tap mask (x^8+x^6+x^5+x^4+1, maximal for 8 bits).
- SEED_DEFAULT, 8'h01, reset state. Also substituted for an all-zero seed and used for lock-up recovery. Must be nonzero.
- CNT_W, WIDTH, width of the period counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- step_en  in  1  advance the LFSR by STEPS shifts this cycle
- seed_we  in  1  load seed into state
- seed  in  WIDTH  seed value
- taps_we  in  1  load taps into the tap register
- taps  in  WIDTH  tap mask (bit i set = XOR feedback into bit i)
- state  out  WIDTH  current LFSR state (registered)
- out_bit  out  1  state[0]
- wrap  out  1  one-cycle pulse: state returned to the reference seed
- period_last  out  CNT_W  enabled-cycle count of the last completed period
- lockup  out  1  one-cycle pulse: zero-state recovery occurred

Behaviour:
- Reset (synchronous, rst_n=0 at posedge clk):
  - state=SEED_DEFAULT, taps_r=TAPS_DEFAULT, ref=SEED_DEFAULT.
  - cnt=0, period_last=0, wrap=0, lockup=0.
  - Reset overrides all inputs. Reset mid-sequence discards the count.
- One shift, Galois right-shift: s' = (s >> 1) ^ (s[0] ? taps_r : 0).
  - STEPS shifts are unrolled combinationally. One enabled cycle = STEPS shifts.
- Priority per cycle: seed_we > step_en.
- taps_we is independent of the state update:
  - taps_r updates at the clock edge.
  - A step in the same cycle uses the old taps_r.
- seed_we=1:
  - state = (seed==0 ? SEED_DEFAULT : seed), and ref takes the same value.
  - cnt=0; step_en is ignored that cycle. wrap=0, lockup=0.
- step_en=1, no seed_we, state!=0:
  - state <= next.
  - If next==ref: wrap=1, period_last=cnt+1, cnt=0.
  - Otherwise: cnt=cnt+1, wrapping modulo 2^CNT_W with no flag.
- step_en=1, no seed_we, state==0 (reachable only with a tap mask whose MSB is clear):
  - state=SEED_DEFAULT, ref=SEED_DEFAULT, cnt=0, lockup=1. No wrap.
- step_en=0 and no seed_we: state, cnt and ref hold. wrap=0, lockup=0.
- Output timing:
  - wrap and lockup are registered and high for exactly one cycle after the causing edge.
  - All outputs are registered; latency from input to state is 1 cycle.
  - out_bit is combinational from registered state.
- Writing taps does not reset cnt or ref. With a non-maximal mask, period_last reports the actual cycle length from ref; if the cycle never reaches ref, wrap never fires.

Decomposition:
- Package lfsr_pkg:
  - Maximal-length default tap constants for widths 4..32.
  - Function default_taps(width).
  - Function galois_shift(state, taps) for a single shift.
- Sub-module lfsr_step_comb: purely combinational, parametrised by WIDTH/STEPS, chains STEPS galois_shift calls.
- lfsr_gen holds the registers, priority logic, period monitor and lock-up recovery.

Test Plan:
- Defaults (WIDTH=8, STEPS=1), reset, seed_we with 0x01, then step 5 cycles -> state 0xB8, 0x5C, 0x2E, 0x17, 0xB3.
- After reset, step_en high 255 cycles -> wrap pulses once, on the 255th step with state=0x01. period_last=255. No other wrap in 510 cycles; second wrap at cycle 510.
- seed_we with seed=0x00 -> state=0x01, wrap=0, lockup=0. Same cycle with step_en=1 -> state still 0x01 (load wins).
- taps_we 0x00, seed 0x01, step -> state 0x00. Step again -> state 0x01, lockup pulse one cycle. taps_we 0xB8 plus step in the same cycle -> shift uses taps 0x00.
- STEPS=2 instance: seed 0x01, one enabled cycle -> state 0x5C. 127/128 cycle wrap check: wrap after 255 shifts is not aligned, so period_last=255 in enabled cycles (LCM behaviour).
- Mid-sequence rst_n=0 for 1 cycle with step_en held high -> state=0x01, period_last=0, cnt restarts. First wrap comes 255 cycles after reset release.
